// File: rtl/sobel_row_sequencer.sv
// Walks an image in vertical strips NUM_ACC outputs wide: fetches row chunks top to bottom
// and, once three rows are resident, issues one masked result write per new row.
module sobel_row_sequencer #(
    parameter int NUM_ACC = 8,
    parameter int ADDR_W  = 32,
    parameter int DIM_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic [DIM_W-1:0]   n_cols,
    input  logic [DIM_W-1:0]   n_rows,
    input  logic [ADDR_W-1:0]  in_base,
    input  logic [ADDR_W-1:0]  out_base,
    output logic               rd_req,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic               rd_gnt,
    input  logic               rd_valid,
    output logic               row_shift,
    output logic               wr_req,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [NUM_ACC-1:0] wr_be,
    input  logic               wr_gnt,
    output logic               busy,
    output logic               done
);
    // Column counter is wide enough to overshoot n_cols by one strip without wrapping.
    localparam int CW = DIM_W + $clog2(NUM_ACC + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [DIM_W-1:0]   r_n_cols;
    logic [DIM_W-1:0]   r_n_rows;
    logic [ADDR_W-1:0]  r_in_base;
    logic [ADDR_W-1:0]  r_out_base;
    logic [CW-1:0]      r_col;
    logic [DIM_W-1:0]   r_row;
    logic [ADDR_W-1:0]  r_roff;
    logic [1:0]         r_rows_loaded;
    logic               r_rd_req;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_wr_req;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [NUM_ACC-1:0] r_wr_be;
    logic               r_busy;
    logic               r_done;

    logic [CW-1:0]      w_last_col;
    logic [CW-1:0]      w_next_col;
    logic [CW-1:0]      w_adv_col;
    logic [DIM_W-1:0]   w_adv_row;
    logic [ADDR_W-1:0]  w_adv_roff;
    logic [ADDR_W-1:0]  w_adv_rd_addr;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [NUM_ACC-1:0] w_wr_be;
    logic               w_row_last;
    logic               w_third_row;
    logic               w_do_advance;
    logic               w_adv_finish;

    // Last writable output column is n_cols-2; the captured n_cols is always >= 3 here.
    assign w_last_col    = CW'(r_n_cols) - CW'(2);
    assign w_next_col    = r_col + CW'(NUM_ACC);
    assign w_row_last    = (r_row == r_n_rows - DIM_W'(1));
    assign w_third_row   = (r_rows_loaded >= 2'd2);
    assign w_do_advance  = ((r_state == S_WAIT) && rd_valid && !w_third_row) ||
                           ((r_state == S_WRITE) && wr_gnt);

    assign w_adv_col     = w_row_last ? w_next_col : r_col;
    assign w_adv_row     = w_row_last ? '0 : r_row + DIM_W'(1);
    assign w_adv_roff    = w_row_last ? '0 : r_roff + ADDR_W'(r_n_cols);
    assign w_adv_finish  = w_row_last && (w_next_col >= w_last_col);
    assign w_adv_rd_addr = r_in_base + w_adv_roff + ADDR_W'(w_adv_col);
    assign w_wr_addr     = r_out_base + r_roff - ADDR_W'(r_n_cols) + ADDR_W'(r_col) + ADDR_W'(1);

    always_comb begin
        // NOTE: default assignment first so no bit of the mask can infer a latch.
        w_wr_be = '0;
        for (int k = 0; k < NUM_ACC; k++) begin
            w_wr_be[k] = ((r_col + CW'(k + 1)) <= w_last_col);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_n_cols      <= '0;
            r_n_rows      <= '0;
            r_in_base     <= '0;
            r_out_base    <= '0;
            r_col         <= '0;
            r_row         <= '0;
            r_roff        <= '0;
            r_rows_loaded <= '0;
            r_rd_req      <= 1'b0;
            r_rd_addr     <= '0;
            r_wr_req      <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_be       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_n_cols      <= n_cols;
                        r_n_rows      <= n_rows;
                        r_in_base     <= in_base;
                        r_out_base    <= out_base;
                        r_col         <= '0;
                        r_row         <= '0;
                        r_roff        <= '0;
                        r_rows_loaded <= '0;
                        r_busy        <= 1'b1;
                        if ((n_cols < DIM_W'(3)) || (n_rows < DIM_W'(3))) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state   <= S_READ;
                            r_rd_req  <= 1'b1;
                            r_rd_addr <= in_base;
                        end
                    end
                end
                S_READ: begin
                    if (rd_gnt) begin
                        r_rd_req <= 1'b0;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rd_valid) begin
                        if (r_rows_loaded != 2'd3) begin
                            r_rows_loaded <= r_rows_loaded + 2'd1;
                        end
                        if (w_third_row) begin
                            r_state   <= S_WRITE;
                            r_wr_req  <= 1'b1;
                            r_wr_addr <= w_wr_addr;
                            r_wr_be   <= w_wr_be;
                        end
                    end
                end
                S_WRITE: begin
                    if (wr_gnt) begin
                        r_wr_req <= 1'b0;
                    end
                end
                S_DONE: begin
                    // First DONE cycle raises done; the second returns to IDLE.
                    if (!r_done) begin
                        r_done <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Shared step to the next row, or to the top of the next strip.
            if (w_do_advance) begin
                r_col  <= w_adv_col;
                r_row  <= w_adv_row;
                r_roff <= w_adv_roff;
                if (w_row_last) begin
                    r_rows_loaded <= '0;
                end
                if (w_adv_finish) begin
                    r_state <= S_DONE;
                end else begin
                    r_state   <= S_READ;
                    r_rd_req  <= 1'b1;
                    r_rd_addr <= w_adv_rd_addr;
                end
            end
        end
    end

    // NOTE: row_shift is decoded rather than registered so it lands in the rd_valid cycle itself.
    assign row_shift = (r_state == S_WAIT) && rd_valid;
    assign rd_req    = r_rd_req;
    assign rd_addr   = r_rd_addr;
    assign wr_req    = r_wr_req;
    assign wr_addr   = r_wr_addr;
    assign wr_be     = r_wr_be;
    assign busy      = r_busy;
    assign done      = r_done;
endmodule

// File: tb/tb_sobel_row_sequencer.sv
// Randomized bench for sobel_row_sequencer: a strip/row loop model predicts every read,
// write and mask; the bus side applies random or fixed grant and data latencies.
module tb_sobel_row_sequencer;
    localparam int NA = 8;
    localparam int AW = 32;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          go;
    logic [DW-1:0] n_cols;
    logic [DW-1:0] n_rows;
    logic [AW-1:0] in_base;
    logic [AW-1:0] out_base;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_valid;
    logic          row_shift;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [NA-1:0] wr_be;
    logic          wr_gnt;
    logic          busy;
    logic          done;

    int n_err = 0;
    int n_chk = 0;

    sobel_row_sequencer #(.NUM_ACC(NA), .ADDR_W(AW), .DIM_W(DW)) dut (
        .clk(clk), .reset(reset), .go(go), .n_cols(n_cols), .n_rows(n_rows),
        .in_base(in_base), .out_base(out_base),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
        .row_shift(row_shift),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_be(wr_be), .wr_gnt(wr_gnt),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_req"}, rd_req, 0);
        check({tag, "_wr_req"}, wr_req, 0);
        check({tag, "_row_shift"}, row_shift, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_be"}, wr_be, 0);
    endtask

    // Images with a dimension below 3: no bus traffic, done two cycles after go.
    task automatic run_degen(input int cols, input int rows);
        @(negedge clk);
        n_cols = DW'(cols); n_rows = DW'(rows); go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        check("degen_busy_c1", busy, 1);
        check("degen_done_c1", done, 0);
        check("degen_req_c1", rd_req | wr_req, 0);
        @(negedge clk);
        check("degen_busy_c2", busy, 1);
        check("degen_done_c2", done, 1);
        check("degen_req_c2", rd_req | wr_req, 0);
        @(negedge clk);
        check("degen_busy_c3", busy, 0);
        check("degen_done_c3", done, 0);
    endtask

    task automatic run_image(input int cols, input int rows, input logic [AW-1:0] ib,
                             input logic [AW-1:0] ob, input int max_dly, input bit rnd_dly,
                             input bit spam, input bit spur, input bit abort_wr);
        logic [AW-1:0] exp_rd[$];
        logic [AW-1:0] obs_rd[$];
        logic [AW-1:0] exp_wa[$];
        logic [AW-1:0] obs_wa[$];
        logic [NA-1:0] exp_be[$];
        logic [NA-1:0] obs_be[$];
        logic [AW-1:0] a;
        logic [NA-1:0] be;
        logic [AW-1:0] rd_hold = '0;
        logic [AW-1:0] wr_hold = '0;
        bit rd_pend = 0;
        bit wr_pend = 0;
        bit awaiting = 0;
        bit fin = 0;
        bit exp_shift;
        int rd_left = 0;
        int wr_left = 0;
        int data_left = 0;
        int n_shift = 0;

        if (cols >= 3 && rows >= 3) begin
            for (int c = 0; c < cols - 2; c += NA) begin
                for (int r = 0; r < rows; r++) begin
                    a = ib + AW'(r * cols + c);
                    exp_rd.push_back(a);
                    if (r >= 2) begin
                        a = ob + AW'((r - 1) * cols + c + 1);
                        exp_wa.push_back(a);
                        for (int k = 0; k < NA; k++) be[k] = (c + 1 + k <= cols - 2);
                        exp_be.push_back(be);
                    end
                end
            end
        end

        @(negedge clk);
        n_cols = DW'(cols); n_rows = DW'(rows); in_base = ib; out_base = ob; go = 1'b1;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            @(negedge clk);
            go = 1'b0; rd_gnt = 1'b0; wr_gnt = 1'b0; rd_valid = 1'b0; exp_shift = 1'b0;
            check("busy", busy, 1);
            if (rd_req && wr_req) check("req_overlap", 1, 0);
            if (done) fin = 1;
            if (spam && !done) begin
                go = 1'($urandom);
                n_cols = DW'($urandom); n_rows = DW'($urandom);
                in_base = $urandom; out_base = $urandom;
            end

            if (abort_wr && wr_req) begin
                reset = 1'b1;
                #1;
                check_all_zero("abort");
                return;
            end

            if (rd_pend && !rd_req) begin check("rd_req_held", 0, 1); rd_pend = 0; end
            if (rd_req) begin
                if (!rd_pend) begin
                    rd_pend = 1; rd_hold = rd_addr;
                    rd_left = rnd_dly ? int'($urandom_range(max_dly, 0)) : max_dly;
                end else begin
                    check("rd_addr_stable", rd_addr, rd_hold);
                end
                if (rd_left == 0) begin
                    rd_gnt = 1'b1; obs_rd.push_back(rd_addr); rd_pend = 0; awaiting = 1;
                    data_left = rnd_dly ? int'($urandom_range(max_dly, 0)) : max_dly;
                end else begin
                    rd_left--;
                    if (spur) rd_valid = 1'b1;
                end
            end else if (awaiting) begin
                if (data_left == 0) begin
                    rd_valid = 1'b1; exp_shift = 1'b1; awaiting = 0;
                end else begin
                    data_left--;
                end
            end

            if (wr_pend && !wr_req) begin check("wr_req_held", 0, 1); wr_pend = 0; end
            if (wr_req) begin
                if (!wr_pend) begin
                    wr_pend = 1; wr_hold = wr_addr;
                    wr_left = rnd_dly ? int'($urandom_range(max_dly, 0)) : max_dly;
                end else begin
                    check("wr_addr_stable", wr_addr, wr_hold);
                end
                if (wr_left == 0) begin
                    wr_gnt = 1'b1; obs_wa.push_back(wr_addr); obs_be.push_back(wr_be); wr_pend = 0;
                end else begin
                    wr_left--;
                end
            end

            #1;
            if (row_shift) n_shift++;
            if (rd_valid) check(exp_shift ? "row_shift" : "spurious_shift", row_shift, exp_shift);
        end

        if (!fin) check("timeout_done", 0, 1);
        @(negedge clk);
        go = 1'b0;
        check("done_width", done, 0);
        check("busy_after_done", busy, 0);
        check("n_reads", obs_rd.size(), exp_rd.size());
        for (int i = 0; i < obs_rd.size() && i < exp_rd.size(); i++) check("rd_addr", obs_rd[i], exp_rd[i]);
        check("n_writes", obs_wa.size(), exp_wa.size());
        for (int i = 0; i < obs_wa.size() && i < exp_wa.size(); i++) begin
            check("wr_addr", obs_wa[i], exp_wa[i]);
            check("wr_be", obs_be[i], exp_be[i]);
        end
        check("n_row_shift", n_shift, exp_rd.size());
    endtask

    initial begin
        reset = 1'b1; go = 1'b0; n_cols = '0; n_rows = '0; in_base = '0; out_base = '0;
        rd_gnt = 1'b0; rd_valid = 1'b0; wr_gnt = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reference images with immediate grants.
        run_image(10, 4, 32'h1000, 32'h2000, 0, 0, 0, 0, 0);
        run_image(12, 3, 32'h1000, 32'h2000, 0, 0, 0, 0, 0);

        run_degen(2, 100);
        run_degen(10, 2);

        // Five-cycle stalls on both grants and data, with rd_valid noise during READ.
        run_image(10, 4, 32'h1000, 32'h2000, 5, 0, 0, 1, 0);
        run_image(20, 5, 32'h3000, 32'h4000, 5, 0, 0, 1, 0);

        // Reset in the middle of a write, then a clean rerun.
        run_image(10, 4, 32'h1000, 32'h2000, 0, 0, 0, 0, 1);
        @(negedge clk);
        check("idle_in_reset_busy", busy, 0);
        reset = 1'b0;
        run_image(10, 4, 32'h1000, 32'h2000, 0, 0, 0, 0, 0);

        // go and image inputs thrashed while busy.
        run_image(12, 3, 32'h1000, 32'h2000, 2, 1, 1, 0, 0);

        // Random geometry, bases near the wrap point, random latencies.
        for (int n = 0; n < 8; n++) begin
            run_image(int'($urandom_range(30, 3)), int'($urandom_range(8, 3)),
                      (n % 2 == 0) ? 32'hFFFF_FFC0 + AW'($urandom_range(63, 0)) : $urandom,
                      $urandom, 3, 1, 1'($urandom), 1'($urandom), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sobel_row_sequencer.md
SOBEL_ROW_SEQUENCER -- requirements
Module: sobel_row_sequencer

Interface
REQ-001 Parameter NUM_ACC, default 8: number of Sobel cores; output pixels produced per write.
REQ-002 Parameter ADDR_W, default 32: byte-address width.
REQ-003 Parameter DIM_W, default 16: width of image dimension inputs.
REQ-004 clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 go  in  1  start pulse; sampled only in IDLE.
REQ-007 n_cols, n_rows  in  DIM_W each  image width and height in pixels; captured on accepted go.
REQ-008 in_base, out_base  in  ADDR_W each  input and output image byte base addresses; captured on accepted go.
REQ-009 rd_req / rd_addr / rd_gnt  out / out ADDR_W / in 1  read-chunk request, its address, and acceptance.
REQ-010 rd_valid  in  1  the requested (NUM_ACC+2)-byte chunk is present on the row-register input this cycle.
REQ-011 row_shift  out  1  one-cycle pulse: row1<=row2, row2<=row3, row3<=fetched chunk.
REQ-012 wr_req / wr_addr / wr_be / wr_gnt  out / out ADDR_W / out NUM_ACC / in 1  result-write request, address, byte enables, and acceptance.
REQ-013 busy, done  out  1 each  busy is high outside IDLE; done is a one-cycle completion pulse.

Function
REQ-014 States SHALL be IDLE, READ, WAIT, WRITE, DONE.
REQ-015 IDLE: on go=1, capture the inputs, clear col, row and rows_loaded, and go to READ; if n_cols<3 or n_rows<3, go to DONE instead, with no transactions.
REQ-016 READ: hold rd_req=1 with a stable rd_addr = in_base + row*n_cols + col until rd_gnt=1, then go to WAIT; the row term SHALL come from an accumulator incremented by n_cols (no multiplier).
REQ-017 WAIT: on rd_valid, pulse row_shift in that same cycle, saturate-increment rows_loaded at 3, and go to WRITE if rows_loaded (after increment) is 3, else to ADVANCE logic.
REQ-018 rd_valid outside WAIT SHALL be ignored; no row_shift is generated.
REQ-019 WRITE: hold wr_req=1 with stable wr_addr = out_base + (row-1)*n_cols + col + 1 until wr_gnt=1, then apply ADVANCE logic.
REQ-020 wr_be bit k SHALL be 1 iff col+1+k <= n_cols-2; the last strip is partial, and border pixels are never written.
REQ-021 ADVANCE: if row < n_rows-1, then row++ and go to READ; otherwise set row=0 and rows_loaded=0, col += NUM_ACC, and go to DONE if the new col >= n_cols-2, else to READ.
REQ-022 DONE: assert done for exactly one cycle, then go to IDLE.
REQ-023 go while busy SHALL be ignored and SHALL have no side effect on captured values.
REQ-024 rd_req and wr_req SHALL never be high in the same cycle; a request SHALL not drop before its grant.
REQ-025 A grant arriving in the same cycle the request first rises SHALL be accepted (zero-wait handshake), so that READ and WRITE each take a minimum of 1 cycle.
REQ-026 Address arithmetic SHALL be ADDR_W bits, wrapping modulo 2^ADDR_W; col, row and row-offset counters SHALL be DIM_W+ADDR_W-safe, with no overflow for n_cols, n_rows < 2^DIM_W.
REQ-027 Totals per image: reads = n_rows*S and writes = (n_rows-2)*S, where S = ceil((n_cols-2)/NUM_ACC).

Reset
REQ-028 reset=1 SHALL immediately force IDLE and drive rd_req, wr_req, row_shift, busy and done to 0, rd_addr, wr_addr and wr_be to 0, and all counters to 0, including mid-transaction.
REQ-029 After reset deasserts, the block SHALL wait for a new go; there is no resumption of an aborted image.

Verification
REQ-030 NUM_ACC=8, n_cols=10, n_rows=4, in_base=0x1000, out_base=0x2000, grants immediate -> reads at 0x1000, 0x100A, 0x1014, 0x101E; writes at 0x200B, 0x2015 with wr_be=0xFF; one done pulse.
REQ-031 n_cols=12, n_rows=3 -> reads at 0x1000, 0x100C, 0x1018, 0x1008, 0x1014, 0x1020; writes at 0x200D (be=0xFF) and 0x2015 (be=0x03).
REQ-032 n_cols=2, n_rows=100 with go -> no rd_req or wr_req; done pulses 2 cycles after go; busy high for exactly those 2 cycles.
REQ-033 rd_gnt and wr_gnt held low 5 cycles each -> rd_addr and wr_addr remain stable, and exactly one row_shift occurs per rd_valid; a spurious rd_valid in READ is ignored.
REQ-034 reset asserted during WRITE of the REQ-030 case -> all outputs 0 in the same cycle; a subsequent go reproduces the full REQ-030 sequence from the first read.
REQ-035 go pulsed repeatedly while busy -> the transaction count and addresses are identical to the single-go run.
